iir_adv_ctrl: RTL and testbench
===============================

# iir_adv_ctrl

Sequencing controller in front of the advanced IIR filter datapath. It accepts input samples over a valid/ready stream and issues them to the filter as `din`/`vin` pulses, with optional minimum spacing and a bounded number of samples in flight. It also holds a shadow/active coefficient bank so that coefficient updates are written at any time but applied only when the filter pipeline is empty. The result is that no sample is ever processed with a mix of old and new coefficients.

## Interface
- `DW`, 11: sample and coefficient width.
- `MAX_INFLIGHT`, 4: maximum samples issued but not yet returned on `vout`; range 1..7.
- `MIN_GAP`, 0: idle cycles forced between two accepted samples; range 0..15.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  upstream sample valid.
- `s_data`  in  DW  upstream sample.
- `s_ready`  out  1  controller accepts a sample this cycle.
- `din`  out  DW  sample to the filter; registered.
- `vin`  out  1  one-cycle sample strobe to the filter; registered.
- `vout`  in  1  filter output-valid strobe; one per completed sample.
- `cfg_we`  in  1  shadow coefficient write strobe.
- `cfg_addr`  in  3  coefficient select:
  - 0 = b0, 1 = b1, 2 = b2
  - 3 = a1_neg, 4 = a1_2_a2, 5 = a1a2
  - 6 and 7 are ignored.
- `cfg_data`  in  DW  coefficient value.
- `cfg_commit`  in  1  request to apply the shadow bank to the active bank.
- `cfg_busy`  out  1  a commit is in progress.
- `b0`, `b1`, `b2`, `a1_neg`, `a1_2_a2`, `a1a2`  out  DW each  active coefficients to the filter.
- `err`  out  1  sticky flag: `vout` seen with zero samples in flight.

## Operation
- **Reset values:**
  - Shadow and active coefficients are 0.
  - `din` = 0, `vin` = 0, `err` = 0, `cfg_busy` = 0.
  - State = RUN, in-flight count = 0, gap counter = 0.
  - Any pending commit is discarded.
- **Handshake:**
  - A sample is accepted when `s_valid` && `s_ready` at a rising edge.
  - `s_ready` is derived from registered state only: state == RUN, gap counter == 0, and count < `MAX_INFLIGHT`.
  - It never depends on `s_valid` or `cfg_commit`.
- **Issue:**
  - An accepted sample drives `din <= s_data` and `vin <= 1` for exactly one cycle.
  - `din` holds its last value while `vin` = 0.
- **Gap:**
  - On accept, the gap counter loads `MIN_GAP` and then decrements to 0 each cycle.
  - With `MIN_GAP` = 0, back-to-back accepts are allowed.
- **In-flight count:**
  - +1 on accept, −1 on `vout`; unchanged if both happen in the same cycle.
  - If `vout` arrives at count 0: the count stays 0 and `err` is set until reset.
- **FSM:**
  - RUN → DRAIN on `cfg_commit`. A sample handshaken in the same cycle is still accepted and counted.
  - DRAIN: `s_ready` = 0. Go to SWAP when count == 0 and `vin` = 0.
  - SWAP, one cycle: active <= shadow, then RUN.
- **`cfg_busy`** = (state != RUN).
- **`cfg_commit` while busy** is ignored; commits are not queued.
- **`cfg_we`:**
  - Writes the shadow register in any state.
  - A write in the SWAP cycle lands in shadow only; active takes the pre-write shadow value.
  - `cfg_we` in the same cycle as `cfg_commit` in RUN is included in that commit.

## Timing
- Accept at edge t: `vin`/`din` are valid in cycle t+1.
- Commit from RUN with count 0 at edge t:
  - DRAIN in t+1, SWAP in t+2.
  - New coefficients visible and `s_ready` possible again from t+3.
  - `cfg_busy` is high for t+1..t+2.
- Commit with samples in flight: DRAIN lasts until the cycle after the last `vout` brings count to 0.
- Active coefficients change only on the SWAP edge and are registered outputs.
- `rst_n` asserted mid-operation: all outputs return to reset values immediately (asynchronous). In-flight samples are forgotten.

## Structure
- Package `iir_adv_pkg` holds:
  - `DW`
  - the coefficient address constants (`COEF_B0` .. `COEF_A1A2`)
  - the state enum `{RUN, DRAIN, SWAP}`
- Sub-module `iir_coef_bank`: six shadow registers, six active registers, the address decoder and a `swap` input. The FSM, gap counter and in-flight counter stay in the top level.

## Test plan
- **Write and commit:** write b0 = 11'h0A0, a1a2 = 11'h7F0, then commit while idle. Expect the active `b0`/`a1a2` values to appear exactly 3 cycles after the commit, `cfg_busy` high for 2 cycles, and all other coefficients at 0.
- **Streaming:** with `MIN_GAP` = 0 and `MAX_INFLIGHT` = 4, hold `s_valid` high for 6 samples with `vout` tied low. Expect 4 accepts, then `s_ready` = 0. One `vout` pulse re-enables exactly one accept.
- **Gap spacing:** with `MIN_GAP` = 2, hold `s_valid` high continuously. Expect `vin` pulses every 3 cycles and `din` matching the stream order.
- **Commit with samples in flight:** commit with 3 samples in flight, then return `vout` pulses at +5, +9 and +12. Expect the coefficients to be unchanged until 2 cycles after the +12 pulse, and no accepts during DRAIN.
- **Write and repeated commit during SWAP:** do a `cfg_we` and a second `cfg_commit` in the SWAP cycle. Expect active to hold the old shadow value, shadow to hold the new one, and the second commit to be ignored. Also send a stray `vout` at count 0 and expect `err` = 1 until reset.
- **Reset mid-DRAIN:** assert `rst_n` low during DRAIN. Expect all coefficients 0, `cfg_busy` = 0, `vin` = 0, and `s_ready` = 1 in the first cycle after release.

Source files
------------

// File: rtl/iir_adv_ctrl_pkg.sv
// iir_adv_pkg: shared width, coefficient addresses and controller states
package iir_adv_pkg;
  localparam int DW = 11;
  localparam logic [2:0] COEF_B0      = 3'd0;
  localparam logic [2:0] COEF_B1      = 3'd1;
  localparam logic [2:0] COEF_B2      = 3'd2;
  localparam logic [2:0] COEF_A1_NEG  = 3'd3;
  localparam logic [2:0] COEF_A1_2_A2 = 3'd4;
  localparam logic [2:0] COEF_A1A2    = 3'd5;
  typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;
endpackage

// File: rtl/iir_adv_ctrl_coef_bank.sv
// iir_coef_bank: shadow coefficient registers copied to the active bank on swap
module iir_coef_bank
  import iir_adv_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [2:0]    addr,
  input  logic [DW-1:0] data,
  input  logic          swap,
  output logic [DW-1:0] b0,
  output logic [DW-1:0] b1,
  output logic [DW-1:0] b2,
  output logic [DW-1:0] a1_neg,
  output logic [DW-1:0] a1_2_a2,
  output logic [DW-1:0] a1a2
);
  logic [5:0][DW-1:0] shadow, active;
  logic [5:0]         sel;

  // address decode; addresses 6 and 7 select nothing
  always_comb begin
    sel = '0;
    for (int i = 0; i < 6; i++) sel[i] = we && (addr == 3'(i));
  end

  // shadow takes writes any time; active copies the pre-write shadow on swap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
    end else begin
      for (int i = 0; i < 6; i++) if (sel[i]) shadow[i] <= data;
      if (swap) active <= shadow;
    end
  end

  assign b0      = active[COEF_B0];
  assign b1      = active[COEF_B1];
  assign b2      = active[COEF_B2];
  assign a1_neg  = active[COEF_A1_NEG];
  assign a1_2_a2 = active[COEF_A1_2_A2];
  assign a1a2    = active[COEF_A1A2];
endmodule

// File: rtl/iir_adv_ctrl.sv
// iir_adv_ctrl: paces samples into the IIR filter and applies coefficient commits only when it is empty
module iir_adv_ctrl
  import iir_adv_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int MIN_GAP      = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic [DW-1:0] din,
  output logic          vin,
  input  logic          vout,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [DW-1:0] cfg_data,
  input  logic          cfg_commit,
  output logic          cfg_busy,
  output logic [DW-1:0] b0,
  output logic [DW-1:0] b1,
  output logic [DW-1:0] b2,
  output logic [DW-1:0] a1_neg,
  output logic [DW-1:0] a1_2_a2,
  output logic [DW-1:0] a1a2,
  output logic          err
);
  localparam logic [2:0] MAX_CNT = 3'(MAX_INFLIGHT);
  localparam logic [3:0] GAP_LD  = 4'(MIN_GAP);

  state_t     state;
  logic [2:0] cnt;
  logic [3:0] gap;
  logic       accept;

  assign s_ready = (state == RUN) && (gap == 4'd0) && (cnt < MAX_CNT);
  assign accept  = s_valid && s_ready;

  // issue register: one-cycle strobe, data held between samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vin <= 1'b0;
      din <= '0;
    end else begin
      vin <= accept;
      if (accept) din <= s_data;
    end
  end

  // spacing counter reloaded on every accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap <= '0;
    else if (accept) gap <= GAP_LD;
    else if (gap != 4'd0) gap <= gap - 4'd1;
  end

  // samples in flight; a return with nothing outstanding is flagged and ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (accept && !vout) cnt <= cnt + 3'd1;
      else if (vout && !accept && cnt != 3'd0) cnt <= cnt - 3'd1;
      if (vout && cnt == 3'd0) err <= 1'b1;
    end
  end

  // commit sequencer: stop issuing, wait for an empty pipe, swap for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      cfg_busy <= 1'b0;
    end else begin
      case (state)
        RUN: if (cfg_commit) begin
          state    <= DRAIN;
          cfg_busy <= 1'b1;
        end
        DRAIN: if (cnt == 3'd0 && !vin) state <= SWAP;
        default: begin
          state    <= RUN;
          cfg_busy <= 1'b0;
        end
      endcase
    end
  end

  iir_coef_bank u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (cfg_we),
    .addr    (cfg_addr),
    .data    (cfg_data),
    .swap    (state == SWAP),
    .b0      (b0),
    .b1      (b1),
    .b2      (b2),
    .a1_neg  (a1_neg),
    .a1_2_a2 (a1_2_a2),
    .a1a2    (a1a2)
  );
endmodule

// File: tb/tb_iir_adv_ctrl.sv
// tb_iir_adv_ctrl: table and sequence checks of the IIR sequencing controller
module tb_iir_adv_ctrl;
  import iir_adv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s_valid, s_ready, vin, vout, cfg_we, cfg_commit, cfg_busy, err;
  logic [DW-1:0] s_data, din, cfg_data, b0, b1, b2, a1_neg, a1_2_a2, a1a2;
  logic [2:0]    cfg_addr;

  logic          g_valid, g_ready, g_vin, g_busy, g_err;
  logic [DW-1:0] g_data, g_din, g_b0, g_b1, g_b2, g_a1n, g_a12, g_a1a2;

  iir_adv_ctrl #(.MAX_INFLIGHT(4), .MIN_GAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .din(din), .vin(vin), .vout(vout), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .b0(b0), .b1(b1),
    .b2(b2), .a1_neg(a1_neg), .a1_2_a2(a1_2_a2), .a1a2(a1a2), .err(err)
  );

  iir_adv_ctrl #(.MAX_INFLIGHT(4), .MIN_GAP(2)) dut_g (
    .clk(clk), .rst_n(rst_n), .s_valid(g_valid), .s_data(g_data), .s_ready(g_ready),
    .din(g_din), .vin(g_vin), .vout(g_vin), .cfg_we(1'b0), .cfg_addr(3'd0),
    .cfg_data('0), .cfg_commit(1'b0), .cfg_busy(g_busy), .b0(g_b0), .b1(g_b1),
    .b2(g_b2), .a1_neg(g_a1n), .a1_2_a2(g_a12), .a1a2(g_a1a2), .err(g_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [DW-1:0] coef [6];
  always_comb begin
    coef[0] = b0;
    coef[1] = b1;
    coef[2] = b2;
    coef[3] = a1_neg;
    coef[4] = a1_2_a2;
    coef[5] = a1a2;
  end

  // scoreboard: accepted samples are queued and must reappear in order on din/vin
  logic [DW-1:0] q[$], qg[$];
  always @(posedge clk) begin
    if (rst_n && s_valid && s_ready) q.push_back(s_data);
    if (rst_n && g_valid && g_ready) qg.push_back(g_data);
  end

  always @(negedge clk) begin
    if (rst_n && vin) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL din_pop: got vin with din %0h, required no issue", din);
      end else chk("din", din, q.pop_front());
    end
    if (rst_n && g_vin) begin
      if (qg.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL gap_din_pop: got vin with din %0h, required no issue", g_din);
      end else chk("gap_din", g_din, qg.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100us");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0]    addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl [8];

  initial begin
    int k, last, nv;
    logic r;
    tbl = '{
      '{3'd0, 11'h123, 11'h123}, '{3'd1, 11'h2B4, 11'h2B4}, '{3'd6, 11'h7FF, 11'h000},
      '{3'd2, 11'h045, 11'h045}, '{3'd3, 11'h7A1, 11'h7A1}, '{3'd7, 11'h555, 11'h000},
      '{3'd4, 11'h3E8, 11'h3E8}, '{3'd5, 11'h611, 11'h611}
    };
    s_valid = 0; s_data = '0; vout = 0; cfg_we = 0; cfg_addr = '0; cfg_data = '0; cfg_commit = 0;
    g_valid = 0; g_data = '0;

    // reset state
    cyc(3);
    chk("rst_b0", b0, 0);
    chk("rst_a1a2", a1a2, 0);
    chk("rst_vin", vin, 0);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1;
    chk("rst_ready", s_ready, 1);

    // write and commit while idle; the second write shares the commit cycle
    cfg_we = 1; cfg_addr = COEF_B0; cfg_data = 11'h0A0;
    cyc(1);
    cfg_addr = COEF_A1A2; cfg_data = 11'h7F0; cfg_commit = 1;
    cyc(1);
    cfg_we = 0; cfg_commit = 0;
    for (int j = 1; j <= 3; j++) begin
      if (j < 3) begin
        chk("wc_old_b0", b0, 0);
        chk("wc_busy", cfg_busy, 1);
        chk("wc_ready", s_ready, 0);
      end else begin
        chk("wc_busy_end", cfg_busy, 0);
        chk("wc_b0", b0, 11'h0A0);
        chk("wc_a1a2", a1a2, 11'h7F0);
        chk("wc_b1", b1, 0);
        chk("wc_b2", b2, 0);
        chk("wc_a1_neg", a1_neg, 0);
        chk("wc_a1_2_a2", a1_2_a2, 0);
        chk("wc_ready_end", s_ready, 1);
      end
      cyc(1);
    end

    // table: full bank write including ignored addresses, then commit
    for (int i = 0; i < 8; i++) begin
      cfg_we = 1; cfg_addr = tbl[i].addr; cfg_data = tbl[i].wdata;
      cyc(1);
    end
    cfg_we = 0; cfg_commit = 1;
    cyc(1);
    cfg_commit = 0;
    cyc(2);
    for (int i = 0; i < 8; i++)
      if (tbl[i].addr < 3'd6) chk($sformatf("tbl_coef%0d", tbl[i].addr), coef[tbl[i].addr], tbl[i].exp);

    // streaming: in-flight limit of 4, one return frees one slot
    k = 0; s_valid = 1; s_data = 11'h100;
    for (int c = 0; c < 8; c++) begin
      r = s_ready;
      cyc(1);
      if (r) begin k++; s_data = 11'(32'h100 + k); end
    end
    chk("stream_acc4", k, 4);
    chk("stream_full", s_ready, 0);
    vout = 1;
    cyc(1);
    vout = 0;
    chk("stream_reopen", s_ready, 1);
    for (int c = 0; c < 4; c++) begin
      r = s_ready;
      cyc(1);
      if (r) begin k++; s_data = 11'(32'h100 + k); end
    end
    s_valid = 0;
    chk("stream_acc5", k, 5);
    chk("stream_full2", s_ready, 0);

    // commit with 3 in flight, returns at +5, +9, +12
    vout = 1;
    cyc(1);
    vout = 0;
    cfg_we = 1; cfg_addr = COEF_B1; cfg_data = 11'h155; cfg_commit = 1;
    cyc(1);
    cfg_we = 0; cfg_commit = 0; s_valid = 1; s_data = 11'h2AA;
    for (int j = 1; j <= 15; j++) begin
      vout = (j == 5 || j == 9 || j == 12);
      if (j < 15) begin
        chk($sformatf("drain_b1_c%0d", j), b1, tbl[1].exp);
        chk($sformatf("drain_busy_c%0d", j), cfg_busy, 1);
        chk($sformatf("drain_ready_c%0d", j), s_ready, 0);
      end else begin
        chk("drain_new_b1", b1, 11'h155);
        chk("drain_busy_end", cfg_busy, 0);
        chk("drain_ready_end", s_ready, 1);
        s_valid = 0;
      end
      cyc(1);
    end
    vout = 0;

    // write and second commit during the SWAP cycle
    chk("err_clear", err, 0);
    cfg_we = 1; cfg_addr = COEF_B2; cfg_data = 11'h011;
    cyc(1);
    cfg_we = 0; cfg_commit = 1;
    cyc(1);
    cfg_commit = 0;
    cyc(1);
    chk("swap_busy", cfg_busy, 1);
    cfg_we = 1; cfg_addr = COEF_B2; cfg_data = 11'h022; cfg_commit = 1;
    cyc(1);
    cfg_we = 0; cfg_commit = 0;
    chk("swap_b2_old_shadow", b2, 11'h011);
    chk("swap_busy_off", cfg_busy, 0);
    cyc(1);
    chk("swap_commit_ignored", cfg_busy, 0);
    chk("swap_b2_hold", b2, 11'h011);
    cfg_commit = 1;
    cyc(1);
    cfg_commit = 0;
    cyc(2);
    chk("swap_b2_new_shadow", b2, 11'h022);

    // stray return with nothing outstanding
    vout = 1;
    cyc(1);
    vout = 0;
    chk("err_set", err, 1);
    cyc(5);
    chk("err_sticky", err, 1);

    // reset in the middle of a drain
    s_valid = 1; s_data = 11'h3C3;
    cyc(1);
    s_data = 11'h3C4;
    cyc(1);
    s_valid = 0; cfg_commit = 1;
    cyc(1);
    cfg_commit = 0;
    cyc(1);
    chk("rd_busy", cfg_busy, 1);
    chk("rd_b0_pre", b0, tbl[0].exp);
    #2 rst_n = 0;
    #1;
    chk("rd_b0", b0, 0);
    chk("rd_b1", b1, 0);
    chk("rd_b2", b2, 0);
    chk("rd_a1_neg", a1_neg, 0);
    chk("rd_a1_2_a2", a1_2_a2, 0);
    chk("rd_a1a2", a1a2, 0);
    chk("rd_busy_async", cfg_busy, 0);
    chk("rd_vin", vin, 0);
    chk("rd_err", err, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1;
    cyc(1);
    chk("rd_ready_after", s_ready, 1);
    chk("rd_busy_after", cfg_busy, 0);
    chk("rd_vin_after", vin, 0);

    // gap spacing on the MIN_GAP=2 instance
    g_valid = 1; g_data = 11'h050; last = -1; nv = 0;
    for (int c = 0; c < 20; c++) begin
      r = g_ready;
      if (g_vin) begin
        nv++;
        if (last >= 0) chk($sformatf("gap_spacing_c%0d", c), c - last, 3);
        last = c;
      end
      cyc(1);
      if (r) g_data = g_data + 11'd1;
    end
    g_valid = 0;
    chk("gap_count", nv, 7);

    cyc(3);
    chk("sb_empty", q.size(), 0);
    chk("sb_gap_empty", qg.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
